plru_replace: RTL



---
 rtl/plru_replace_pkg.sv | 52 +++++
 rtl/plru_tree.sv | 36 +++
 rtl/plru_replace.sv | 100 ++++++++++
 3 files changed

// File: rtl/plru_replace_pkg.sv
// Shared tree pseudo-LRU helpers for the cache and BTB replacement engines.
// Trees are carried left-aligned in a fixed-width vector so one function body serves every associativity.
package plru_replace_pkg;

  localparam int unsigned PLRU_WAY_NUM    = 4;
  localparam int unsigned PLRU_NODE_NUM   = PLRU_WAY_NUM - 1;
  localparam int unsigned PLRU_MAX_LEVELS = 6;
  localparam int unsigned PLRU_MAX_NODES  = (1 << PLRU_MAX_LEVELS) - 1;

  typedef logic [PLRU_MAX_NODES-1:0]  plru_vec_t;
  typedef logic [PLRU_MAX_LEVELS-1:0] plru_idx_t;

  // Point every node on the path to `way` away from it.
  function automatic plru_vec_t plru_touch(input plru_vec_t tree, input plru_idx_t way,
                                           input int unsigned levels = $clog2(PLRU_WAY_NUM));
    plru_vec_t t;
    plru_idx_t wa;
    plru_idx_t node;
    logic      b;
    t    = tree;
    wa   = way << (PLRU_MAX_LEVELS - levels);
    node = '0;
    for (int unsigned lvl = 0; lvl < PLRU_MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        b       = wa[PLRU_MAX_LEVELS-1];
        t[node] = ~b;
        node    = (node << 1) + plru_idx_t'(1) + plru_idx_t'(b);
        wa      = wa << 1;
      end
    end
    return t;
  endfunction

  // Follow the node bits from the root down to a leaf.
  function automatic plru_idx_t plru_victim(input plru_vec_t tree,
                                            input int unsigned levels = $clog2(PLRU_WAY_NUM));
    plru_idx_t node;
    plru_idx_t way;
    logic      b;
    node = '0;
    way  = '0;
    for (int unsigned lvl = 0; lvl < PLRU_MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        b    = tree[node];
        way  = (way << 1) | plru_idx_t'(b);
        node = (node << 1) + plru_idx_t'(1) + plru_idx_t'(b);
      end
    end
    return way;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational single-set PLRU block: ordered touch chain, then victim of the resulting tree
// with preference for the lowest invalid way.
module plru_tree
  import plru_replace_pkg::*;
#(
  parameter int unsigned WAY_NUM   = 4,
  parameter int unsigned TOUCH_NUM = 1,
  localparam int unsigned WAY_WIDTH = $clog2(WAY_NUM),
  localparam int unsigned NODE_NUM  = WAY_NUM - 1
) (
  input  logic [NODE_NUM-1:0]            cur_tree,
  input  logic [TOUCH_NUM-1:0]           touch_en,
  input  logic [TOUCH_NUM*WAY_WIDTH-1:0] touch_way,
  input  logic [WAY_NUM-1:0]             query_valid,
  output logic [NODE_NUM-1:0]            next_tree,
  output logic [WAY_WIDTH-1:0]           victim
);

  always_comb begin
    plru_vec_t t;
    t = '0;
    t[NODE_NUM-1:0] = cur_tree;
    for (int p = 0; p < int'(TOUCH_NUM); p++) begin
      if (touch_en[p]) begin
        t = plru_touch(t, plru_idx_t'(touch_way[p*WAY_WIDTH +: WAY_WIDTH]), WAY_WIDTH);
      end
    end
    next_tree = t[NODE_NUM-1:0];
    victim    = WAY_WIDTH'(plru_victim(t, WAY_WIDTH));
    // Descending scan so the lowest invalid way is the one left standing.
    for (int i = int'(WAY_NUM) - 1; i >= 0; i--) begin
      if (!query_valid[i]) victim = WAY_WIDTH'(i);
    end
  end

endmodule

// File: rtl/plru_replace.sv
// Multi-port tree pseudo-LRU replacement engine with invalid-way preference and refill update.
// Optional macro REPLACE_BYPASS_EN forwards same-cycle hits/refill into the victim query.
module plru_replace
  import plru_replace_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned WAY_NUM   = 4,
  parameter int unsigned READ_PORT = 1,
  localparam int unsigned WAY_WIDTH  = $clog2(WAY_NUM),
  localparam int unsigned ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [READ_PORT-1:0]            hit_en,
  input  logic [READ_PORT*WAY_WIDTH-1:0]  hit_way,
  input  logic [READ_PORT*ADDR_WIDTH-1:0] hit_index,
  input  logic [ADDR_WIDTH-1:0]           miss_index,
  input  logic [WAY_NUM-1:0]              miss_valid,
  output logic [WAY_WIDTH-1:0]            miss_way,
  input  logic                            refill_en,
  input  logic [ADDR_WIDTH-1:0]           refill_index,
  input  logic [WAY_WIDTH-1:0]            refill_way
);

  localparam int unsigned NODE_NUM  = WAY_NUM - 1;
  localparam int unsigned TOUCH_NUM = READ_PORT + 1;

  logic [NODE_NUM-1:0]  tree_q [DEPTH];
  logic [NODE_NUM-1:0]  tree_d [DEPTH];
  logic [WAY_WIDTH-1:0] unused_victim [DEPTH];

  // Per-set update chain: hit ports in order, refill last.
  for (genvar s = 0; s < int'(DEPTH); s++) begin : g_set
    logic [TOUCH_NUM-1:0]           touch_en;
    logic [TOUCH_NUM*WAY_WIDTH-1:0] touch_way;

    always_comb begin
      touch_en = '0;
      for (int p = 0; p < int'(READ_PORT); p++) begin
        touch_en[p] = hit_en[p] && (hit_index[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(s));
      end
      touch_en[READ_PORT] = refill_en && (refill_index == ADDR_WIDTH'(s));
    end

    assign touch_way = {refill_way, hit_way};

    plru_tree #(
      .WAY_NUM   (WAY_NUM),
      .TOUCH_NUM (TOUCH_NUM)
    ) u_tree (
      .cur_tree    (tree_q[s]),
      .touch_en    (touch_en),
      .touch_way   (touch_way),
      .query_valid ({WAY_NUM{1'b1}}),
      .next_tree   (tree_d[s]),
      .victim      (unused_victim[s])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(DEPTH); s++) tree_q[s] <= '0;
    end else begin
      tree_q <= tree_d;
    end
  end

  logic                 miss_in_range;
  logic [NODE_NUM-1:0]  query_tree;
  logic [NODE_NUM-1:0]  unused_query_next;
  logic [WAY_WIDTH-1:0] query_victim;

  assign miss_in_range = 32'(miss_index) < DEPTH;

  always_comb begin
    query_tree = '0;
    if (miss_in_range) begin
`ifdef REPLACE_BYPASS_EN
      query_tree = tree_d[miss_index];
`else
      query_tree = tree_q[miss_index];
`endif
    end
  end

  plru_tree #(
    .WAY_NUM   (WAY_NUM),
    .TOUCH_NUM (1)
  ) u_query (
    .cur_tree    (query_tree),
    .touch_en    (1'b0),
    .touch_way   ('0),
    .query_valid (miss_valid),
    .next_tree   (unused_query_next),
    .victim      (query_victim)
  );

  assign miss_way = miss_in_range ? query_victim : '0;

endmodule
